// File: rtl/raster_dispatcher_pkg.sv
// Shared types for the raster dispatcher: triangle record, FSM states and
// a pointer-width helper used by the dispatcher and its queue.
package raster_pkg;

  localparam int TRI_W = 386;

  typedef struct packed {
    logic [8:0][31:0] vtx;
    logic [2:0][23:0] rgb;
    logic [25:0]      fb_base;
  } tri_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_dispatcher_if.sv
// Upstream triangle stream plus rasterizer-lane bus of the dispatcher.
interface raster_dispatcher_if #(
  parameter int NUM_RAST = 2
);

  raster_pkg::tri_t      tri_in;
  logic                  tri_valid;
  logic                  tri_last;
  logic                  tri_ready;
  raster_pkg::tri_t      rast_tri;
  logic [NUM_RAST-1:0]   rast_valid;
  logic [NUM_RAST-1:0]   rast_done;
  logic                  frame_done;
  logic                  busy;
  logic [15:0]           tri_done_cnt;

  modport slave (
    input  tri_in, tri_valid, tri_last, rast_done,
    output tri_ready, rast_tri, rast_valid, frame_done, busy, tri_done_cnt
  );

  modport master (
    output tri_in, tri_valid, tri_last, rast_done,
    input  tri_ready, rast_tri, rast_valid, frame_done, busy, tri_done_cnt
  );

endinterface

// File: rtl/raster_dispatcher_tri_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push and pop may occur together.
module tri_fifo
  import raster_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/raster_dispatcher.sv
// Queues triangles and hands each to the next free rasterizer lane in
// round-robin order; tracks per-frame completion and pulses frame_done.
module raster_dispatcher
  import raster_pkg::*;
#(
  parameter int NUM_RAST   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clock,
  input logic                reset,
  raster_dispatcher_if.slave bus
);

  localparam int PTR_W = ptr_w(NUM_RAST);

  state_e              r_state;
  logic [NUM_RAST-1:0] r_lane_busy;
  logic [NUM_RAST-1:0] r_rast_valid;
  logic [PTR_W-1:0]    r_rr_ptr;
  tri_t                r_rast_tri;
  logic                r_frame_done;
  logic [15:0]         r_done_cnt;

  logic                w_tri_ready;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [TRI_W:0]      w_head;
  logic                w_unused_last;
  tri_t                w_head_tri;
  logic                w_found;
  logic [PTR_W-1:0]    w_grant_idx;
  logic [PTR_W-1:0]    w_next_ptr;
  logic [NUM_RAST-1:0] w_grant;
  logic [NUM_RAST-1:0] w_done_hit;
  logic [15:0]         w_done_add;

  tri_fifo #(.WIDTH(TRI_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .wdata ({bus.tri_last, bus.tri_in}),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign {w_unused_last, w_head_tri} = w_head;
  assign w_tri_ready = !w_full && ((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_push      = bus.tri_valid && w_tri_ready;
  assign w_done_hit  = bus.rast_done & r_lane_busy;
  assign w_pop       = w_found && !w_empty;
  assign w_next_ptr  = (w_grant_idx == PTR_W'(NUM_RAST - 1)) ? '0 : w_grant_idx + 1'b1;

  // Two ascending scans: lanes at/after rr_ptr first, then the wrapped ones.
  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int l = 0; l < NUM_RAST; l++) begin
      if (!w_found && !r_lane_busy[l] && (l >= int'(r_rr_ptr))) begin
        w_found     = 1'b1;
        w_grant_idx = PTR_W'(l);
      end
    end
    for (int l = 0; l < NUM_RAST; l++) begin
      if (!w_found && !r_lane_busy[l] && (l < int'(r_rr_ptr))) begin
        w_found     = 1'b1;
        w_grant_idx = PTR_W'(l);
      end
    end
  end

  always_comb begin
    w_grant    = '0;
    w_done_add = '0;
    for (int l = 0; l < NUM_RAST; l++) begin
      w_grant[l] = w_pop && (w_grant_idx == PTR_W'(l));
      w_done_add = w_done_add + 16'(w_done_hit[l]);
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE:  if (w_push) r_state <= bus.tri_last ? S_DRAIN : S_RUN;
        S_RUN:   if (w_push && bus.tri_last) r_state <= S_DRAIN;
        S_DRAIN: if (w_empty && !(|r_lane_busy) && !(|r_rast_valid)) begin
                   r_state      <= S_DONE;
                   r_frame_done <= 1'b1;
                 end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lane_busy  <= '0;
      r_rast_valid <= '0;
      r_rr_ptr     <= '0;
      r_rast_tri   <= '0;
      r_done_cnt   <= '0;
    end else begin
      r_rast_valid <= w_grant;
      r_lane_busy  <= (r_lane_busy & ~w_done_hit) | w_grant;
      if (w_pop) begin
        r_rast_tri <= w_head_tri;
        r_rr_ptr   <= w_next_ptr;
      end
      // Count holds through S_DONE and clears as the FSM returns to idle.
      if (r_state == S_DONE) r_done_cnt <= '0;
      else                   r_done_cnt <= r_done_cnt + w_done_add;
    end
  end

  assign bus.tri_ready    = w_tri_ready;
  assign bus.rast_tri     = r_rast_tri;
  assign bus.rast_valid   = r_rast_valid;
  assign bus.frame_done   = r_frame_done;
  assign bus.busy         = (r_state != S_IDLE) || !w_empty;
  assign bus.tri_done_cnt = r_done_cnt;

endmodule

// File: tb/tb_raster_dispatcher.sv
// Self-checking bench: directed table, hand-written corner sequences and a
// randomized run against a queue-based reference model of the dispatcher.
module tb_raster_dispatcher;
  import raster_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  raster_dispatcher_if #(.NUM_RAST(NR)) bus ();

  raster_dispatcher #(.NUM_RAST(NR), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic          valid;
    logic          last;
    logic [NR-1:0] done;
    logic [NR-1:0] exp_rv;
    logic          exp_fd;
    logic [15:0]   exp_cnt;
    logic          exp_ready;
    logic          exp_busy;
    logic          exp_is_t0;
  } vec_t;

  typedef struct packed {
    logic             last;
    logic [TRI_W-1:0] t;
  } entry_t;

  // Reference model: queue of waiting triangles, lane occupancy, frame flags.
  entry_t           m_q[$];
  logic [NR-1:0]    m_busy;
  int               m_rr;
  int               m_cnt;
  bit               m_started, m_closed, m_done_now;
  logic [NR-1:0]    m_rv;
  logic [TRI_W-1:0] m_tri;

  task automatic check(input string name, input logic [TRI_W-1:0] act, input logic [TRI_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic [TRI_W-1:0] t, input logic [NR-1:0] d);
    bus.tri_valid = v;
    bus.tri_last  = l;
    bus.tri_in    = t;
    bus.rast_done = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [TRI_W-1:0] rand_tri();
    logic [TRI_W-1:0] v;
    for (int i = 0; i < TRI_W; i++) v[i] = 1'($urandom);
    return v;
  endfunction

  function automatic vec_t mk(input logic v, input logic l, input logic [NR-1:0] d,
                              input logic [NR-1:0] rv, input logic fd, input int cnt,
                              input logic rdy, input logic bsy, input logic is_t0);
    vec_t r;
    r.valid = v; r.last = l; r.done = d; r.exp_rv = rv; r.exp_fd = fd;
    r.exp_cnt = 16'(cnt); r.exp_ready = rdy; r.exp_busy = bsy; r.exp_is_t0 = is_t0;
    return r;
  endfunction

  task automatic check_out(input string tag, input logic [NR-1:0] rv, input logic [TRI_W-1:0] t,
                           input logic fd, input logic [15:0] cnt, input logic rdy, input logic bsy);
    check({tag, ".rast_valid"},   bus.rast_valid,   rv);
    check({tag, ".rast_tri"},     bus.rast_tri,     t);
    check({tag, ".frame_done"},   bus.frame_done,   fd);
    check({tag, ".tri_done_cnt"}, bus.tri_done_cnt, cnt);
    check({tag, ".tri_ready"},    bus.tri_ready,    rdy);
    check({tag, ".busy"},         bus.busy,         bsy);
  endtask

  function automatic bit m_ready();
    return (m_q.size() < DEPTH) && !m_closed && !m_done_now;
  endfunction

  function automatic bit m_busy_out();
    return m_started || m_closed || m_done_now || (m_q.size() != 0);
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_busy = '0; m_rr = 0; m_cnt = 0;
    m_started = 0; m_closed = 0; m_done_now = 0;
    m_rv = '0; m_tri = '0;
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic m_step(input logic v, input logic l, input logic [TRI_W-1:0] t, input logic [NR-1:0] d);
    logic [NR-1:0] busy_pre;
    bit            accept, drained, issued;
    int            qn, lane;
    entry_t        e;
    busy_pre = m_busy;
    accept   = v && m_ready();
    qn       = m_q.size();
    drained  = m_closed && !m_done_now && (qn == 0) && (busy_pre == '0) && (m_rv == '0);
    for (int k = 0; k < NR; k++)
      if (d[k] && busy_pre[k]) begin
        m_cnt     = (m_cnt + 1) % 65536;
        m_busy[k] = 1'b0;
      end
    m_rv   = '0;
    issued = 0;
    if (qn > 0)
      for (int k = 0; k < NR; k++) begin
        lane = (m_rr + k) % NR;
        if (!issued && !busy_pre[lane]) begin
          issued       = 1;
          e            = m_q.pop_front();
          m_tri        = e.t;
          m_rv[lane]   = 1'b1;
          m_busy[lane] = 1'b1;
          m_rr         = (lane + 1) % NR;
        end
      end
    if (accept) begin
      m_q.push_back({l, t});
      if (l) m_closed = 1;
      else   m_started = 1;
    end
    if (m_done_now) begin
      m_done_now = 0; m_cnt = 0; m_started = 0; m_closed = 0;
    end else if (drained) begin
      m_done_now = 1;
    end
  endtask

  vec_t             tbl[14];
  logic [TRI_W-1:0] t0, ta, tb, tc, td;
  logic [TRI_W-1:0] p[8];
  int               accepted;
  logic             rv_in, rl_in;
  logic [TRI_W-1:0] rt_in;
  logic [NR-1:0]    rd_in;

  initial begin
    drive(1'b0, 1'b0, '0, '0);
    tick();
    do_reset();

    // Single triangle frame: issue two cycles after the push, frame_done two after the lane finishes.
    t0 = rand_tri();
    tbl[0]  = mk(1, 1, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 2'b00, 2'b01, 0, 0, 0, 1, 1);
    for (int r = 3; r < 10; r++) tbl[r] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1);
    tbl[10] = mk(0, 0, 2'b01, 2'b00, 0, 0, 0, 1, 1);
    tbl[11] = mk(0, 0, 2'b00, 2'b00, 0, 1, 0, 1, 1);
    tbl[12] = mk(0, 0, 2'b00, 2'b00, 1, 1, 0, 1, 1);
    tbl[13] = mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1);
    for (int r = 0; r < 14; r++) begin
      check_out($sformatf("tbl%0d", r), tbl[r].exp_rv, tbl[r].exp_is_t0 ? t0 : '0,
                tbl[r].exp_fd, tbl[r].exp_cnt, tbl[r].exp_ready, tbl[r].exp_busy);
      drive(tbl[r].valid, tbl[r].last, t0, tbl[r].done);
      tick();
    end

    // Round-robin: lane0, lane1, third waits until lane0 frees up.
    do_reset();
    ta = rand_tri(); tb = rand_tri(); tc = rand_tri();
    drive(1, 0, ta, 2'b00); tick();
    drive(1, 0, tb, 2'b00); tick();
    check("rr.c2.rv", bus.rast_valid, 2'b01); check("rr.c2.tri", bus.rast_tri, ta);
    drive(1, 1, tc, 2'b00); tick();
    check("rr.c3.rv", bus.rast_valid, 2'b10); check("rr.c3.tri", bus.rast_tri, tb);
    drive(0, 0, tc, 2'b00); tick();
    check("rr.c4.rv", bus.rast_valid, 2'b00); check("rr.c4.hold", bus.rast_tri, tb);
    tick(); tick();
    drive(0, 0, tc, 2'b01); tick();
    check("rr.c7.rv", bus.rast_valid, 2'b00); check("rr.c7.cnt", bus.tri_done_cnt, 16'd1);
    drive(0, 0, tc, 2'b00); tick();
    check("rr.c8.rv", bus.rast_valid, 2'b01); check("rr.c8.tri", bus.rast_tri, tc);
    drive(0, 0, tc, 2'b10); tick();
    drive(0, 0, tc, 2'b01); tick();
    drive(0, 0, tc, 2'b00);
    check("rr.c10.fd", bus.frame_done, 1'b0); tick();
    check("rr.c11.fd", bus.frame_done, 1'b1); check("rr.c11.cnt", bus.tri_done_cnt, 16'd3); tick();
    check("rr.c12.fd", bus.frame_done, 1'b0); check("rr.c12.cnt", bus.tri_done_cnt, 16'd0);
    check("rr.c12.ready", bus.tri_ready, 1'b1);

    // Back-pressure: both lanes occupied, only FIFO_DEPTH pushes fit.
    do_reset();
    ta = rand_tri(); tb = rand_tri();
    drive(1, 0, ta, 2'b00); tick();
    drive(1, 0, tb, 2'b00); tick();
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      p[i] = rand_tri();
      check($sformatf("bp.ready%0d", i), bus.tri_ready, (i < DEPTH) ? 1'b1 : 1'b0);
      if (bus.tri_ready) accepted++;
      drive(1, 0, p[i], 2'b00);
      tick();
    end
    check("bp.accepted", 32'(accepted), 32'(DEPTH));
    drive(0, 0, '0, 2'b01); tick();
    check("bp.c11.ready", bus.tri_ready, 1'b0);
    drive(0, 0, '0, 2'b00); tick();
    check("bp.c12.ready", bus.tri_ready, 1'b1);
    check("bp.c12.rv", bus.rast_valid, 2'b01); check("bp.c12.tri", bus.rast_tri, p[0]);

    // Simultaneous dones count twice, then both queued triangles issue back to back.
    do_reset();
    ta = rand_tri(); tb = rand_tri(); tc = rand_tri(); td = rand_tri();
    drive(1, 0, ta, 2'b00); tick();
    drive(1, 0, tb, 2'b00); tick();
    drive(1, 0, tc, 2'b00); tick();
    drive(1, 1, td, 2'b00); tick();
    drive(0, 0, '0, 2'b00); tick();
    drive(0, 0, '0, 2'b11); tick();
    check("sim.c6.cnt", bus.tri_done_cnt, 16'd2); check("sim.c6.rv", bus.rast_valid, 2'b00);
    drive(0, 0, '0, 2'b00); tick();
    check("sim.c7.rv", bus.rast_valid, 2'b01); check("sim.c7.tri", bus.rast_tri, tc); tick();
    check("sim.c8.rv", bus.rast_valid, 2'b10); check("sim.c8.tri", bus.rast_tri, td);
    drive(0, 0, '0, 2'b11); tick();
    drive(0, 0, '0, 2'b00);
    check("sim.c9.fd", bus.frame_done, 1'b0); check("sim.c9.cnt", bus.tri_done_cnt, 16'd4); tick();
    check("sim.c10.fd", bus.frame_done, 1'b1); check("sim.c10.cnt", bus.tri_done_cnt, 16'd4);

    // Spurious done on an idle lane, then reset in the middle of draining.
    do_reset();
    ta = rand_tri();
    drive(1, 1, ta, 2'b00); tick();
    drive(0, 0, '0, 2'b00); tick();
    check("sp.c2.rv", bus.rast_valid, 2'b01); tick();
    drive(0, 0, '0, 2'b10); tick();
    check("sp.c4.cnt", bus.tri_done_cnt, 16'd0); check("sp.c4.ready", bus.tri_ready, 1'b0);
    do_reset();
    check_out("rst", 2'b00, '0, 1'b0, 16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("rst.fd%0d", i), bus.frame_done, 1'b0);
      check($sformatf("rst.cnt%0d", i), bus.tri_done_cnt, 16'd0);
      drive(0, 0, '0, (i == 0) ? 2'b01 : 2'b00);
      tick();
    end

    // Randomized traffic against the reference model.
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      check_out($sformatf("rnd%0d", c), m_rv, m_tri, m_done_now, 16'(m_cnt), m_ready(), m_busy_out());
      rv_in = ($urandom_range(0, 3) != 0);
      rl_in = ($urandom_range(0, 11) == 0);
      rt_in = rand_tri();
      for (int k = 0; k < NR; k++) rd_in[k] = ($urandom_range(0, 3) == 0);
      drive(rv_in, rl_in, rt_in, rd_in);
      m_step(rv_in, rl_in, rt_in, rd_in);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/raster_dispatcher.md
RASTER_DISPATCHER -- requirements
Module: raster_dispatcher

Interface
REQ-001 Parameter NUM_RAST, default 2, number of rasterizer lanes served.
REQ-002 Parameter FIFO_DEPTH, default 4, triangle queue entries (power of two).
REQ-003 clock  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 tri_in  input  TRI_W  packed triangle: 9x32 vertex coords, 3x24 colours, 26-bit frame-buffer base.
REQ-006 tri_valid  input  1  upstream triangle present.
REQ-007 tri_last  input  1  qualifies tri_valid; triangle is last of frame.
REQ-008 tri_ready  output  1  dispatcher accepts tri_in this cycle.
REQ-009 rast_tri  output  TRI_W  triangle bus shared by all lanes, registered.
REQ-010 rast_valid  output  NUM_RAST  one-hot, one-cycle start pulse to the target lane.
REQ-011 rast_done  input  NUM_RAST  per-lane one-cycle pulse: lane finished its triangle.
REQ-012 frame_done  output  1  one-cycle pulse: every triangle of the frame has completed.
REQ-013 busy  output  1  high whenever state is not S_IDLE or FIFO is non-empty.
REQ-014 tri_done_cnt  output  16  triangles completed in the current frame.

Function
REQ-015 Push occurs when tri_valid && tri_ready; tri_ready = !fifo_full && state in {S_IDLE, S_RUN}.
REQ-016 FIFO: FIFO_DEPTH entries, stores {tri_last, tri_in}; push and pop in the same cycle are both performed.
REQ-017 Lane busy flag sets on the cycle rast_valid is asserted for that lane; clears on that lane's rast_done.
REQ-018 rast_done on a non-busy lane is ignored and is not counted.
REQ-019 Issue: when the FIFO is non-empty and at least one lane is free, pop the head and grant the first free lane at or after rr_ptr (round-robin); rast_tri and rast_valid are registered and appear the next cycle.
REQ-020 rr_ptr advances to the granted lane + 1 (mod NUM_RAST) on each issue; it is unchanged when no issue occurs.
REQ-021 A lane freed by rast_done in cycle N is eligible for grant in cycle N+1, not in cycle N.
REQ-022 Latency: triangle pushed in cycle N into an empty FIFO with a free lane -> rast_valid high in cycle N+2.
REQ-023 At most one issue per cycle; rast_tri holds its last value when rast_valid is 0.
REQ-024 FSM states: S_IDLE, S_RUN, S_DRAIN, S_DONE.
REQ-025 S_IDLE: push with tri_last=0 -> S_RUN; push with tri_last=1 -> S_DRAIN.
REQ-026 S_RUN: push with tri_last=1 -> S_DRAIN; otherwise remain.
REQ-027 S_DRAIN: tri_ready=0; FIFO empty && no lane busy && no rast_valid pending -> S_DONE.
REQ-028 S_DONE: frame_done=1 for exactly this cycle; tri_ready=0; next state S_IDLE.
REQ-029 tri_done_cnt increments on each counted rast_done bit; simultaneous dones on k lanes add k; wraps at 16 bits.
REQ-030 tri_done_cnt clears to 0 on the S_DONE -> S_IDLE transition and keeps its final value during S_DONE.

Reset
REQ-031 On reset: FIFO empty, lane busy flags 0, rr_ptr 0, state S_IDLE, rast_valid 0, rast_tri 0, frame_done 0, tri_done_cnt 0, busy 0; tri_ready is 1 in the first cycle after reset.
REQ-032 Reset asserted mid-frame discards queued and in-flight triangles with no frame_done pulse; later rast_done pulses from lanes are ignored under REQ-018.

Structure
REQ-033 A shared package raster_pkg holds TRI_W (386), the triangle struct typedef and the dispatcher state enum.
REQ-034 The FIFO is one sub-module, tri_fifo (parameterised width/depth, full/empty flags); arbitration and FSM stay in raster_dispatcher.

Verification
REQ-035 Single triangle: push T0 with tri_last=1 at cycle 0 -> rast_valid=2'b01 at cycle 2; rast_done[0] at cycle 10 -> frame_done at cycle 12; tri_done_cnt=1 during S_DONE.
REQ-036 Round-robin: 3 triangles, lanes never done -> grants lane0, lane1; the third triangle stays queued; rast_done[0] -> third triangle goes to lane0 one cycle later.
REQ-037 Back-pressure: 6 pushes with both lanes busy, FIFO_DEPTH=4 -> 4 accepted, tri_ready low on the 5th until a pop.
REQ-038 Simultaneous dones: rast_done=2'b11 in one cycle -> tri_done_cnt increases by 2; both lanes granted on the next two cycles if the FIFO holds 2 triangles.
REQ-039 Spurious and reset: rast_done[1] with lane1 idle -> count unchanged; reset during S_DRAIN -> no frame_done, tri_ready=1 one cycle later.
